// File: rtl/wts_dac_pkg.sv
// Shared constants, soft-start state encoding and arithmetic helpers for the
// wave-table sound DAC output stage.
package wts_dac_pkg;

  localparam logic [11:0] DAC_MID = 12'h800;
  localparam int          INT_W   = 18;

  typedef enum logic [1:0] {
    MUTE,
    RAMP,
    RUN
  } dac_state_e;

  function automatic logic [11:0] step_toward(input logic [11:0] cur, input logic [11:0] tgt);
    if (cur < tgt)      return cur + 12'd1;
    else if (cur > tgt) return cur - 12'd1;
    else                return cur;
  endfunction

  // Rounded average of the two channels; the 13-bit sum cannot overflow.
  function automatic logic [11:0] mono_mix(input logic [11:0] a, input logic [11:0] b);
    return 12'(({1'b0, a} + {1'b0, b} + 13'd1) >> 1);
  endfunction

  // Clamp a two-bit-wider intermediate back into the integrator range.
  function automatic logic [INT_W-1:0] sat_int(input logic [INT_W+1:0] v);
    if ($signed(v) > $signed({3'b000, {(INT_W-1){1'b1}}}))
      return {1'b0, {(INT_W-1){1'b1}}};
    else if ($signed(v) < $signed({3'b111, {(INT_W-1){1'b0}}}))
      return {1'b1, {(INT_W-1){1'b0}}};
    else
      return v[INT_W-1:0];
  endfunction

endpackage

// File: rtl/wts_dac_dsm_channel.sv
// One delta-sigma modulator channel with registered 1-bit output.
// WTS_DAC_SECOND_ORDER_EN selects the second-order loop; default is first order.
module wts_dac_dsm_channel
  import wts_dac_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] x,
  output logic        pdm
);

`ifdef WTS_DAC_SECOND_ORDER_EN
  localparam int EXT = INT_W + 2 - 13;

  logic [12:0]      xs;
  logic [12:0]      fb;
  logic [INT_W-1:0] i1;
  logic [INT_W-1:0] i2;
  logic [INT_W-1:0] i1_nxt;
  logic [INT_W-1:0] i2_nxt;
  logic [INT_W+1:0] i1_sum;
  logic [INT_W+1:0] i2_sum;

  // Offset-binary to signed, and feedback of +/-2048 from the last output bit.
  assign xs = {1'b0, x} - 13'h0800;
  assign fb = pdm ? 13'h0800 : 13'h1800;

  assign i1_sum = {{2{i1[INT_W-1]}}, i1} + {{EXT{xs[12]}}, xs} - {{EXT{fb[12]}}, fb};
  assign i1_nxt = sat_int(i1_sum);
  assign i2_sum = {{2{i2[INT_W-1]}}, i2} + {{2{i1_nxt[INT_W-1]}}, i1_nxt} - {{EXT{fb[12]}}, fb};
  assign i2_nxt = sat_int(i2_sum);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i1  <= '0;
      i2  <= '0;
      pdm <= 1'b0;
    end else begin
      i1  <= i1_nxt;
      i2  <= i2_nxt;
      pdm <= ~i2_nxt[INT_W-1];
    end
  end
`else
  logic [11:0] acc;
  logic [12:0] acc_nxt;

  assign acc_nxt = {1'b0, acc} + {1'b0, x};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      pdm <= 1'b0;
    end else begin
      acc <= acc_nxt[11:0];
      pdm <= acc_nxt[12];
    end
  end
`endif

endmodule

// File: rtl/wts_sound_dac.sv
// Stereo/mono output stage: input registers, mixer, pop-free soft start and two
// delta-sigma channels. WTS_DAC_SECOND_ORDER_EN is honoured inside the channels.
//
// state | meaning
// MUTE  | both channels held at midpoint for MUTE_CYCLES cycles after reset
// RAMP  | every RAMP_DIV cycles each channel steps 1 LSB toward its target
// RUN   | channels follow the mixed target directly; ramp_done high
module wts_sound_dac
  import wts_dac_pkg::*;
#(
  parameter int MUTE_CYCLES = 256,
  parameter int RAMP_DIV    = 16
) (
  input  logic        clk,
  input  logic        slot_nreset,
  input  logic        sw_mono,
  input  logic [11:0] left_in,
  input  logic [11:0] right_in,
  output logic        left_pdm,
  output logic        right_pdm,
  output logic        ramp_done
);

  localparam int MW = (MUTE_CYCLES > 1) ? $clog2(MUTE_CYCLES) : 1;
  localparam int DW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [MW-1:0] MUTE_LOAD = MW'(MUTE_CYCLES - 1);
  localparam logic [DW-1:0] DIV_LOAD  = DW'(RAMP_DIV - 1);

  logic [11:0] left_q, right_q;
  logic        mono_s1, mono_s2, mono_q;
  logic [11:0] mix_l, mix_r;

  dac_state_e  state, state_nxt;
  logic [MW-1:0] mute_cnt, mute_cnt_nxt;
  logic [DW-1:0] div_cnt, div_cnt_nxt;
  logic [11:0] eff_l, eff_r, eff_l_nxt, eff_r_nxt;
  logic [11:0] step_l, step_r;

  // The synchronised switch gets the same input-register stage as the samples.
  always_ff @(posedge clk or negedge slot_nreset) begin
    if (!slot_nreset) begin
      left_q  <= DAC_MID;
      right_q <= DAC_MID;
      mono_s1 <= 1'b0;
      mono_s2 <= 1'b0;
      mono_q  <= 1'b0;
      mix_l   <= DAC_MID;
      mix_r   <= DAC_MID;
    end else begin
      left_q  <= left_in;
      right_q <= right_in;
      mono_s1 <= sw_mono;
      mono_s2 <= mono_s1;
      mono_q  <= mono_s2;
      if (mono_q) begin
        mix_l <= mono_mix(left_q, right_q);
        mix_r <= mono_mix(left_q, right_q);
      end else begin
        mix_l <= left_q;
        mix_r <= right_q;
      end
    end
  end

  assign step_l = step_toward(eff_l, mix_l);
  assign step_r = step_toward(eff_r, mix_r);

  always_ff @(posedge clk or negedge slot_nreset) begin
    if (!slot_nreset) begin
      state    <= MUTE;
      mute_cnt <= MUTE_LOAD;
      div_cnt  <= DIV_LOAD;
      eff_l    <= DAC_MID;
      eff_r    <= DAC_MID;
    end else begin
      state    <= state_nxt;
      mute_cnt <= mute_cnt_nxt;
      div_cnt  <= div_cnt_nxt;
      eff_l    <= eff_l_nxt;
      eff_r    <= eff_r_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    mute_cnt_nxt = mute_cnt;
    div_cnt_nxt  = div_cnt;
    eff_l_nxt    = eff_l;
    eff_r_nxt    = eff_r;
    unique case (state)
      MUTE: begin
        eff_l_nxt = DAC_MID;
        eff_r_nxt = DAC_MID;
        if (mute_cnt == '0) begin
          state_nxt   = RAMP;
          div_cnt_nxt = DIV_LOAD;
        end else begin
          mute_cnt_nxt = mute_cnt - 1'b1;
        end
      end
      RAMP: begin
        if (div_cnt == '0) begin
          div_cnt_nxt = DIV_LOAD;
          eff_l_nxt   = step_l;
          eff_r_nxt   = step_r;
          // Leave on the tick where the step lands both channels on target.
          if (step_l == mix_l && step_r == mix_r) state_nxt = RUN;
        end else begin
          div_cnt_nxt = div_cnt - 1'b1;
        end
      end
      RUN: begin
        eff_l_nxt = mix_l;
        eff_r_nxt = mix_r;
      end
      default: state_nxt = MUTE;
    endcase
  end

  assign ramp_done = (state == RUN);

  wts_dac_dsm_channel u_dsm_l (
    .clk   (clk),
    .rst_n (slot_nreset),
    .x     (eff_l),
    .pdm   (left_pdm)
  );

  wts_dac_dsm_channel u_dsm_r (
    .clk   (clk),
    .rst_n (slot_nreset),
    .x     (eff_r),
    .pdm   (right_pdm)
  );

endmodule

// File: tb/tb_wts_sound_dac.sv
// Self-checking bench for wts_sound_dac: soft-start timing, async reset,
// pulse densities, latency and mono mixing against an arithmetic reference.
module tb_wts_sound_dac;

  localparam int MUTE_CYCLES = 256;
  localparam int RAMP_DIV    = 16;
  localparam int MID         = 2048;

  logic        clk = 1'b0;
  logic        slot_nreset = 1'b1;
  logic        sw_mono = 1'b0;
  logic [11:0] left_in = 12'h800;
  logic [11:0] right_in = 12'h800;
  logic        left_pdm, right_pdm, ramp_done;

  int err_cnt = 0;
  int chk_cnt = 0;

  wts_sound_dac #(.MUTE_CYCLES(MUTE_CYCLES), .RAMP_DIV(RAMP_DIV)) dut (
    .clk         (clk),
    .slot_nreset (slot_nreset),
    .sw_mono     (sw_mono),
    .left_in     (left_in),
    .right_in    (right_in),
    .left_pdm    (left_pdm),
    .right_pdm   (right_pdm),
    .ramp_done   (ramp_done)
  );

  always #23 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    chk_cnt++;
    if (got != exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: cycles from reset release until RUN, from the soft-start rules.
  function automatic int ref_ramp_cycles(input int l, input int r);
    int dl, dr, steps;
    dl = (l > MID) ? l - MID : MID - l;
    dr = (r > MID) ? r - MID : MID - r;
    steps = (dl > dr) ? dl : dr;
    if (steps < 1) steps = 1;
    return MUTE_CYCLES + RAMP_DIV * steps;
  endfunction

  // Reference: ones per 4096 cycles for a channel, from the mixer rules.
  function automatic int ref_density(input int own, input int other, input bit mono);
    return mono ? (own + other + 1) / 2 : own;
  endfunction

  task automatic reset_now(input string tag);
    slot_nreset = 1'b0;
    #1;
    chk({tag, "_lpdm"}, int'(left_pdm), 0);
    chk({tag, "_rpdm"}, int'(right_pdm), 0);
    chk({tag, "_done"}, int'(ramp_done), 0);
  endtask

  task automatic release_and_time(output int n);
    @(negedge clk);
    slot_nreset = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!ramp_done && n < 40000);
  endtask

  task automatic measure(input int ncyc, output int ones_l, output int ones_r);
    ones_l = 0;
    ones_r = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(posedge clk); #1;
      ones_l += int'(left_pdm);
      ones_r += int'(right_pdm);
    end
  endtask

  task automatic idle(input int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int n, ol, or_, prev, lv, rv, k;
    bit mono;

    #10;
    reset_now("rst");
    idle(3);

    release_and_time(n);
    chk("idle_ramp_done", n, ref_ramp_cycles(MID, MID));

    prev = int'(left_pdm);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("idle_alternate", prev ^ int'(left_pdm), 1);
      prev = int'(left_pdm);
    end
    measure(4096, ol, or_);
    chk("idle_dens_l", ol, 2048);
    chk("idle_dens_r", or_, 2048);

    reset_now("rst_run");
    left_in  = 12'h810;
    right_in = 12'h800;
    release_and_time(n);
    chk("ramp_810", n, ref_ramp_cycles(32'h810, 32'h800));

    reset_now("rst_rnd");
    lv = MID - 24 + int'($urandom_range(48, 0));
    rv = MID - 24 + int'($urandom_range(48, 0));
    left_in  = 12'(lv);
    right_in = 12'(rv);
    release_and_time(n);
    chk("ramp_random", n, ref_ramp_cycles(lv, rv));

    // Reset mid-ramp, taken right after a cycle where left_pdm was high.
    reset_now("rst_pre");
    left_in  = 12'h820;
    right_in = 12'h800;
    @(negedge clk);
    slot_nreset = 1'b1;
    idle(400);
    k = 0;
    do begin
      @(posedge clk); #1;
      k++;
    end while (!left_pdm && k < 8);
    chk("midramp_sync", int'(left_pdm), 1);
    reset_now("rst_mid");
    release_and_time(n);
    chk("ramp_restart", n, ref_ramp_cycles(32'h820, 32'h800));

    // Extremes: left to 000 right after a high bit leaves a nonzero residue.
    left_in = 12'h800;
    idle(16);
    k = 0;
    do begin
      @(posedge clk); #1;
      k++;
    end while (!left_pdm && k < 8);
    chk("ext_sync", int'(left_pdm), 1);
    left_in  = 12'h000;
    right_in = 12'hFFF;
    idle(8);
    measure(4096, ol, or_);
    chk("ext_zero_l", ol, 0);

    left_in = 12'hFFF;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!left_pdm && n < 20);
    chk("latency", n, 4);

    measure(4096, ol, or_);
    chk("ext_fff_r", or_, 4095);
    chk("ext_fff_l", ol, 4095);

    left_in  = 12'h400;
    right_in = 12'hC01;
    idle(16);
    sw_mono = 1'b1;
    idle(16);
    measure(4096, ol, or_);
    chk("mono_l", ol, ref_density(32'h400, 32'hC01, 1'b1));
    chk("mono_r", or_, ref_density(32'hC01, 32'h400, 1'b1));

    for (int t = 0; t < 3; t++) begin
      lv   = int'($urandom_range(4095, 0));
      rv   = int'($urandom_range(4095, 0));
      mono = 1'($urandom_range(1, 0));
      left_in  = 12'(lv);
      right_in = 12'(rv);
      sw_mono  = mono;
      idle(16);
      measure(4096, ol, or_);
      chk("rand_l", ol, ref_density(lv, rv, mono));
      chk("rand_r", or_, ref_density(rv, lv, mono));
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/wts_sound_dac.md
# wts_sound_dac

Output stage placed directly downstream of the wave-table sound cartridge core. It takes the core's two 12-bit digital sound outputs and converts them to two 1-bit pulse-density streams that drive an external RC low-pass filter. Features:
- optional mono mixing from the board switch;
- a pop-free soft start after reset;
- one delta-sigma modulator per channel.

## Interface
Parameters:
- MUTE_CYCLES, 256: cycles held at midpoint after reset before ramping.
- RAMP_DIV, 16: clk cycles per ±1 ramp step.

Ports:
- clk  in  1  21.47727 MHz system clock, the same clock as the sound core.
- slot_nreset  in  1  one clock; reset is asynchronous and active-low.
- sw_mono  in  1  board switch, asynchronous to clk; 1 selects mono.
- left_in  in  12  core left sample, unsigned offset-binary, midpoint 12'h800.
- right_in  in  12  core right sample, same format.
- left_pdm  out  1  left pulse-density output, registered.
- right_pdm  out  1  right pulse-density output, registered.
- ramp_done  out  1  high once the soft start has completed (state RUN).

## Operation
- **Reset values:** all outputs 0; state MUTE; accumulators 0; effective samples 12'h800.
- **Input stage:**
  - left_in and right_in are registered every cycle.
  - sw_mono passes through a 2-flop synchronizer.
- **Mixer:**
  - Mono: m = (L + R + 1) >> 1, computed with a 13-bit sum. Both channels receive m.
  - Stereo: L and R pass unchanged.
  - Result is registered.
- **Soft-start FSM:**
  - MUTE: effective = 12'h800 on both channels. Counts MUTE_CYCLES cycles, then goes to RAMP.
  - RAMP:
    - Every RAMP_DIV cycles, each channel's effective sample moves 1 step toward its mixed target.
    - A channel already equal to its target holds.
    - When both channels equal their targets on a step tick, the FSM goes to RUN.
  - RUN:
    - effective = mixed target, direct and unlimited.
    - ramp_done = 1.
    - The FSM stays in RUN until reset.
- **Modulator (first order, default):**
  - 13-bit acc_next = {1'b0, acc[11:0]} + x.
  - pdm <= acc_next[12], registered.
  - The density of ones equals x/4096 exactly over any 4096-cycle window once x has been stable for 4096 cycles.
- **Boundary conditions:**
  - x = 12'h000 gives a constant 0.
  - x = 12'hFFF gives 4095 ones per 4096 cycles.
  - The sw_mono toggle in RUN takes effect immediately, with no ramp.
  - Reset asserted mid-ramp or in RUN returns everything to the reset values asynchronously.
  - Release of reset is the first cycle counted by MUTE.

## Timing
- Latency from a left_in change to the first affected left_pdm bit, in RUN: 4 clk cycles (input reg, mix reg, effective reg, modulator/output reg).
- sw_mono: 2 additional cycles for the synchronizer.
- Worst-case ramp length: 2048 × RAMP_DIV cycles (32768 cycles, ≈1.53 ms at the default).
- No handshake. The samples are sampled every cycle, and the core's sample-rate updates need no strobe.

## Configuration
- WTS_DAC_SECOND_ORDER_EN defined: each channel uses a second-order modulator.
  - xs = x − 2048 (signed, 13 bit).
  - fb = pdm ? +2048 : −2048.
  - i1 += xs − fb; i2 += i1 − fb.
  - 18-bit signed integrators, saturating.
  - pdm <= (i2 >= 0).
  - Long-run density is still x/4096.
- Undefined: the first-order modulator described above.
- Latency and ports are identical in both builds.

## Structure
- Package wts_dac_pkg holds:
  - DAC_MID = 12'h800;
  - the FSM state enum (MUTE, RAMP, RUN);
  - the integrator width constant.
- Sub-module wts_dac_dsm_channel: one modulator instance per channel. It contains the accumulator(s) and the output flop, and carries the WTS_DAC_SECOND_ORDER_EN variants.
- The top holds the synchronizer, mixer, FSM, ramp counters and effective-sample registers.

## Test plan
- **Reset, then idle:**
  - Stimulus: left_in = right_in = 12'h800 from reset.
  - Response: ramp_done rises at cycle MUTE_CYCLES + RAMP_DIV (FSM enters RUN on the first step tick); left_pdm alternates 0,1 with exactly 2048 ones per 4096 cycles.
- **Ramp:**
  - Stimulus: left_in = 12'h810, right_in = 12'h800 at reset release.
  - Response: the left effective sample reaches 12'h810 after 256 + 16×16 cycles; ramp_done rises on that step tick.
- **Extremes in RUN:**
  - left_in = 12'h000 gives 0 ones in 4096 cycles.
  - right_in = 12'hFFF gives 4095 ones per 4096 cycles, measured after 4100 settle cycles.
- **Mono:**
  - Stimulus: in RUN, sw_mono = 1, left_in = 12'h400, right_in = 12'hC01.
  - Response: both outputs have density 12'h801/4096 (2049 ones per 4096 cycles); matching goes live 6 cycles after the switch.
- **Latency:**
  - Stimulus: in RUN, step left_in from 12'h000 to 12'hFFF.
  - Response: the first 1 on left_pdm appears exactly 4 cycles later.
- **Reset mid-ramp:**
  - Stimulus: assert slot_nreset low during RAMP.
  - Response: outputs 0 and ramp_done 0 immediately, without waiting for a clock; after release, MUTE restarts from the count of 0.
